// File: rtl/counter_hex_display_if.sv
// Control/data bundle between the switch/key logic and counter_hex_display.
// DIGITS must match the DIGITS parameter of the attached counter.
interface counter_hex_display_if #(
  parameter int DIGITS = 2
);
  logic                  enable;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic [7*DIGITS-1:0]   HEX;

  modport master (
    output enable, up, load, din,
    input  q, tc, HEX
  );

  modport slave (
    input  enable, up, load, din,
    output q, tc, HEX
  );
endinterface

// File: rtl/counter_hex_display.sv
// Up/down counter with load, cascade tc and active-low 7-segment decode per digit.
// Define COUNTER_BCD_EN for decimal digits; otherwise the count is pure binary.
module counter_hex_display #(
  parameter int DIGITS = 2
) (
  input logic                   clk,
  input logic                   aclr,
  counter_hex_display_if.slave  bus
);
  localparam int W = 4 * DIGITS;

`ifdef COUNTER_BCD_EN
  localparam logic [3:0] DIG_MAX = 4'd9;
`else
  localparam logic [3:0] DIG_MAX = 4'hF;
`endif

  localparam logic [W-1:0] Q_MAX = {DIGITS{DIG_MAX}};

  logic [W-1:0]      q_r;
  logic [W-1:0]      q_step;
  logic [W-1:0]      q_next;
  logic [DIGITS-1:0] at_wrap;
  logic [DIGITS-1:0] carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // ">= DIG_MAX" also catches loaded non-decimal digits in BCD mode (A..F wrap to 0).
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] d;
      assign d = q_r[4*k +: 4];

      assign at_wrap[k] = bus.up ? (d >= DIG_MAX) : (d == 4'd0);

      if (k == 0) begin : g_lsd
        assign carry[k] = 1'b1;
      end else begin : g_upper
        assign carry[k] = &at_wrap[k-1:0];
      end

      always_comb begin
        q_step[4*k +: 4] = d;
        if (carry[k]) begin
          if (bus.up) q_step[4*k +: 4] = at_wrap[k] ? 4'd0 : d + 4'd1;
          else        q_step[4*k +: 4] = at_wrap[k] ? DIG_MAX : d - 4'd1;
        end
      end

      assign bus.HEX[7*k +: 7] = seg7(d);
    end
  endgenerate

  always_comb begin
    q_next = q_r;
    if (bus.load)        q_next = bus.din;
    else if (bus.enable) q_next = q_step;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) q_r <= '0;
    else       q_r <= q_next;
  end

  assign bus.q  = q_r;
  assign bus.tc = bus.enable & (bus.up ? (q_r == Q_MAX) : (q_r == '0));

endmodule

// File: doc/counter_hex_display.md
# counter_hex_display

Parametrised synchronous up/down counter with synchronous load, enable and terminal-count output, driving one active-low seven-segment display per 4-bit digit. It is the next generation of the board-level 4-bit T-counter/HEX demo. It generalises the width to DIGITS nibbles, adds direction and parallel load, and adds a cascade output. It sits between the switch/key inputs and the HEX displays of the lab top levels.

## Interface
- DIGITS, default 2: number of 4-bit digits and seven-segment outputs. Legal range 1–8. Counter width is 4*DIGITS.
- clk  input  1  counter clock; all state changes on the rising edge.
- aclr  input  1  asynchronous reset, active-low. Clears the counter immediately, independent of clk.
- enable  input  1  count enable. Must also be asserted for tc to assert.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load; has priority over counting.
- din  input  4*DIGITS  load value. Digit k occupies din[4k+3:4k].
- q  output  4*DIGITS  current count. Digit k occupies q[4k+3:4k].
- tc  output  1  terminal count, combinational. Asserted when enable=1 and the next count step wraps.
- HEX  output  7*DIGITS  segment drive for digit k on HEX[7k+6:7k].
  - Bit order within a digit, MSB to LSB: a,b,c,d,e,f,g.
  - Active-low: 0 = segment lit.

## Operation
- The asynchronous, active-low reset aclr forces q to all zeros while it is low.
  - This happens whether or not clk is running.
  - Release takes effect at the next rising clk edge.
- Action at each rising clk edge while aclr=1, in priority order:
  - load=1: q ← din. The enable and up inputs are ignored.
  - load=0, enable=1, up=1: q ← q + 1 with wrap-around.
  - load=0, enable=1, up=0: q ← q − 1 with wrap-around.
  - load=0, enable=0: q holds.
- Carry and borrow ripple digit to digit. A digit changes only when every less-significant digit is at its wrap value. This is the generalisation of the T-flip-flop carry chain.
- tc depends on enable, up and q:
  - tc = enable & up & (q == MAX), or enable & ~up & (q == 0).
  - tc ignores load.
  - tc is intended as the enable input of a cascaded instance.
- Segment decode per digit, as a..g with 0 = lit:
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - A: 0001000
  - b: 1100000
  - C: 0110001
  - d: 1000010
  - E: 0110000
  - F: 0111000
- HEX is purely combinational from q. There is no blanking.

## Timing
- Latency: q reflects load or count one rising clk edge after the inputs are sampled.
- HEX and tc settle combinationally in the same cycle that q changes.
- Reset values:
  - q = 0.
  - Each HEX digit = 0000001.
  - tc = enable & ~up.
- Boundary conditions:
  - Wrap-around: MAX+1 gives 0, and 0−1 gives MAX. Both are silent apart from tc having been asserted in the preceding cycle.
  - Simultaneous load and enable: load wins and no count step occurs that cycle.
  - Changing direction mid-count: up is sampled every edge, so there is no hysteresis and no dead cycle.
  - aclr asserted mid-operation: q clears asynchronously. Any pending load or count is lost.

## Configuration
- COUNTER_BCD_EN defined: each digit counts in decimal.
  - Up: a digit ≥ 9 goes to 0 and generates a carry.
  - Down: a digit at 0 goes to 9 and generates a borrow. Any other value decrements by one, so a loaded A goes to 9.
  - MAX = all digits 9.
  - Non-BCD digits can only enter through load. They are displayed with the hex glyphs until the counter passes through them.
- COUNTER_BCD_EN undefined: pure binary count.
  - MAX = 2^(4*DIGITS) − 1.
  - Each digit shows its hex glyph.

## Test plan
- Reset and release: hold aclr=0 for 3 clocks with enable=1 and up=1, then release. Required: q=0 and HEX=0000001_0000001 during reset; q=0x01 after the first edge after release.
- Up-count wrap, binary, DIGITS=2: load 0xFE, then count up 3 edges. Required: q=0xFF with tc=1, then 0x00 with tc=0, then 0x01. HEX digit 1 shows F (0111000) at 0xFF.
- Down-count and direction change: load 0x01, up=0. Required: q=0x00 with tc=1, then 0xFF. Then set up=1: next edge gives q=0x00.
- Load priority and hold: load=1, enable=1, din=0x5A. Required: q=0x5A, HEX = 0100100 (digit 1) and 0001000 (digit 0). Then enable=0 and load=0 for 5 edges: q stays 0x5A.
- BCD mode (COUNTER_BCD_EN), DIGITS=2: load 0x98, count up. Required: 0x99 with tc=1, then 0x00. Load 0x10, count down: required 0x09.
- Asynchronous reset mid-count: drop aclr between clock edges while q=0x37. Required: q=0 before the next rising edge.
